pcm_interp: RTL and testbench
=============================

# pcm_interp

Upsampling front end for the delta-sigma modulator. Accepts signed PCM samples at audio rate over a valid/ready handshake, buffers them in a small FIFO, and emits one signed PCM word per `clk` at 2^OSR_LOG2 times the input rate. Each output is a linear interpolation between consecutive samples. The block feeds the modulator's `pcm` input directly, so the modulator never sees a step larger than one interpolation increment.

## Interface
- `OSR_LOG2`, default 6: log2 of oversampling ratio N (N = 64 output clocks per input sample); legal range 1..10.
- `FIFO_DEPTH_LOG2`, default 2: log2 of input FIFO depth D (D = 4); legal range 1..6.
- `PCM_QUANT`: global sample width macro from the shared header.
- `clk`  in  1: single clock, the modulator's clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  PCM_QUANT: signed input sample.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: FIFO can accept; transfer occurs when `in_valid && in_ready` at a `clk` edge.
- `out_pcm`  out  PCM_QUANT: signed, registered, one sample per `clk`; connects to the modulator's `pcm` input.
- `underrun`  out  1: one-cycle pulse when a segment load finds the FIFO empty.
- `fifo_level`  out  FIFO_DEPTH_LOG2+1: current FIFO occupancy, 0..D.

## Operation
- State machine states:
  - S_FILL: entered on reset. `out_pcm` = 0, phase held at 0.
  - S_RUN: entered when `fifo_level` >= D/2. S_RUN has no exit except reset.
- Phase counter `p` counts 0..N-1 in S_RUN and wraps.
- Segment load happens on the S_FILL->S_RUN edge and on every S_RUN edge where `p` = N-1 (p wraps to 0). It performs:
  - `prev` <= `cur`.
  - If the FIFO is non-empty: pop the head into `cur`.
  - If the FIFO is empty: `cur` is unchanged (output holds at `cur`) and `underrun` pulses for one cycle.
- Initial `prev` = `cur` = 0, so the first segment ramps from 0.
- Accumulator arithmetic:
  - step = `cur` - `prev`, PCM_QUANT+1 bits signed.
  - acc is PCM_QUANT+1+OSR_LOG2 bits.
  - acc = prev·N at phase 0, and acc += step each cycle after that. No multiplier.
- Output rule: `out_pcm` = acc >>> OSR_LOG2, an arithmetic shift (floor). The result always lies between `prev` and `cur` inclusive, so it never overflows PCM_QUANT.
- FIFO behaviour:
  - `in_ready` = (`fifo_level` != D), combinational from the level.
  - A push and a pop in the same cycle are both honoured and the level is unchanged.
  - When the FIFO is full, `in_ready` = 0 even if a pop occurs that cycle.

## Timing
- Reset values: `out_pcm` = 0, `underrun` = 0, `fifo_level` = 0, `in_ready` = 1, state S_FILL, `p` = 0, `prev` = `cur` = acc = 0.
- Reset takes effect immediately and asynchronously, including mid-segment. Any FIFO contents are discarded.
- `out_pcm` for phase p appears one `clk` after the cycle at phase p.
  - Value = prev + floor((cur-prev)·p/N).
  - The first nonzero output can appear 2 clocks after the S_RUN entry edge.
- `underrun` is asserted in the cycle following the failed segment load.
- A pushed sample is visible in `fifo_level` one clock after the handshake.
- Sustained throughput: exactly one pop per N clocks. The upstream source must average at least one sample per N clocks to avoid underrun.

## Configuration
- `PCM_INTERP_EN` defined: linear interpolation as above.
- `PCM_INTERP_EN` undefined: zero-order hold.
  - `out_pcm` = `cur` (registered, same one-clock latency).
  - acc and step logic are removed.
  - FIFO, state machine, phase counter and `underrun` are unchanged.

## Structure
- Shared header (alongside `PCM_QUANT`):
  - `OSR_LOG2` default.
  - State encodings S_FILL = 1'b0, S_RUN = 1'b1.
- One sub-module: `pcm_fifo`.
  - Parameterised synchronous FIFO of width PCM_QUANT and depth 2^FIFO_DEPTH_LOG2.
  - Ports: push, pop, head data, level, full, empty. Asynchronous active-low reset.
- Top level holds the state machine, phase counter, interpolator and output register.

## Test plan
All scenarios use PCM_QUANT = 16, OSR_LOG2 = 2 (N = 4), FIFO_DEPTH_LOG2 = 2 (D = 4), `PCM_INTERP_EN` defined unless stated.
- Reset: hold `rst_n` low, toggle `clk` -> `out_pcm` = 0, `fifo_level` = 0, `in_ready` = 1, `underrun` = 0.
- Ramp and underrun: push 400, then 800, then nothing.
  - `out_pcm` sequence: 0, 100, 200, 300, 400, 500, 600, 700.
  - Then 800 held, with one `underrun` pulse per N clocks.
- Negative floor: push -3, then stall -> `out_pcm` sequence 0, -1, -2, -3, then -3 held.
- Backpressure: hold `in_valid` = 1 with incrementing data every cycle.
  - `in_ready` falls once `fifo_level` = 4.
  - Outputs show each pushed value exactly once, in order; none lost or duplicated.
- Full scale: push -32768, then 32767.
  - Segment values -32768, -16385, -1, 16383 are monotonic.
  - Output then reaches 32767 with no wrap.
- Async reset mid-segment, then `PCM_INTERP_EN` undefined:
  - `out_pcm` = 0 immediately on reset; the next run ramps from 0.
  - With the macro undefined, pushing 400, 800 gives 400×4 then 800×4.

Source files
------------

// File: rtl/pcm_interp_pkg.sv
// +--------------------------------------------------------------------+
// | pcm_interp_pkg : shared sample width, default OSR and FSM states    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pcm_interp_pkg;

  localparam int PCM_QUANT        = 16;
  localparam int OSR_LOG2_DEFAULT = 6;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pcm_fifo.sv
// +--------------------------------------------------------------------+
// | pcm_fifo : synchronous sample FIFO, depth 2^DEPTH_LOG2, head        |
// |            word exposed combinationally                             |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pcm_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcm_interp.sv
// +--------------------------------------------------------------------+
// | pcm_interp : PCM upsampler, linear interpolation by 2^OSR_LOG2      |
// |   PCM_INTERP_EN defined -> linear ramp, undefined -> zero-order hold|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pcm_interp
  import pcm_interp_pkg::*;
#(
  parameter int OSR_LOG2        = OSR_LOG2_DEFAULT,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PCM_QUANT-1:0]       i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [PCM_QUANT-1:0]       o_out_pcm,
  output logic                       o_underrun,
  output logic [FIFO_DEPTH_LOG2:0]   o_fifo_level
);

  localparam int D = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LVL_HALF = (FIFO_DEPTH_LOG2 + 1)'(D / 2);
  localparam logic [OSR_LOG2-1:0]      P_LAST   = '1;
  localparam logic [OSR_LOG2-1:0]      P_ONE    = OSR_LOG2'(1);

  state_e                 r_state;
  logic [OSR_LOG2-1:0]    r_p;
  logic [PCM_QUANT-1:0]   r_cur;
  logic [PCM_QUANT-1:0]   r_out;
  logic                   r_underrun;
  logic [PCM_QUANT-1:0]   w_head;
  logic [FIFO_DEPTH_LOG2:0] w_level;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_load;
  logic                   w_pop;

  assign o_in_ready   = !w_full;
  assign o_out_pcm    = r_out;
  assign o_underrun   = r_underrun;
  assign o_fifo_level = w_level;
  assign w_push       = i_in_valid && o_in_ready;
  assign w_load       = ((r_state == S_FILL) && (w_level >= LVL_HALF)) ||
                        ((r_state == S_RUN)  && (r_p == P_LAST));
  assign w_pop        = w_load && !w_empty;

  pcm_fifo #(
    .WIDTH      (PCM_QUANT),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_in_data),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef PCM_INTERP_EN
  localparam int AW = PCM_QUANT + 1 + OSR_LOG2;

  logic [PCM_QUANT-1:0] r_prev;
  logic signed [AW-1:0] r_acc;
  logic [PCM_QUANT:0]   w_step;

  assign w_step = {r_cur[PCM_QUANT-1], r_cur} - {r_prev[PCM_QUANT-1], r_prev};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_acc  <= '0;
    end else if (w_load) begin
      // New segment starts at the outgoing cur scaled by N
      r_prev <= r_cur;
      r_acc  <= {r_cur[PCM_QUANT-1], r_cur, {OSR_LOG2{1'b0}}};
    end else if (r_state == S_RUN) begin
      r_acc  <= r_acc + {{OSR_LOG2{w_step[PCM_QUANT]}}, w_step};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_p        <= '0;
      r_cur      <= '0;
      r_out      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && w_empty;
      if (w_pop) r_cur <= w_head;
      case (r_state)
        S_FILL: begin
          r_p   <= '0;
          r_out <= '0;
          if (w_load) r_state <= S_RUN;
        end
        default: begin
          r_p <= r_p + P_ONE;
`ifdef PCM_INTERP_EN
          // Floor of acc/N is exactly the bit slice above the fraction
          r_out <= r_acc[OSR_LOG2 +: PCM_QUANT];
`else
          r_out <= r_cur;
`endif
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcm_interp.sv
// +--------------------------------------------------------------------+
// | tb_pcm_interp : directed bench for pcm_interp, N = 4, D = 4         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pcm_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_pcm;
  logic        underrun;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  int ramp_exp [12];
  int neg_exp  [8];
  int fs_exp   [12];
  int bp_base;
  int undr_exp [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

  always #5 clk = ~clk;

  pcm_interp #(
    .OSR_LOG2        (2),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_data    (in_data),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_out_pcm    (out_pcm),
    .o_underrun   (underrun),
    .o_fifo_level (fifo_level)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic reset_dut;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
`ifdef PCM_INTERP_EN
    ramp_exp = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 800, 800, 800};
    neg_exp  = '{0, -1, -2, -3, -3, -3, -3, -3};
    fs_exp   = '{0, -8192, -16384, -24576, -32768, -16385, -1, 16383,
                 32767, 32767, 32767, 32767};
    bp_base  = 0;
`else
    ramp_exp = '{400, 400, 400, 400, 800, 800, 800, 800, 800, 800, 800, 800};
    neg_exp  = '{-3, -3, -3, -3, -3, -3, -3, -3};
    fs_exp   = '{-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767,
                 32767, 32767, 32767, 32767};
    bp_base  = 1;
`endif
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values while rst_n held low
    repeat (3) tick();
    check("rst_out", $signed(out_pcm), 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    check("rst_underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Ramp and underrun
    push(400);
    check("ramp_level1", fifo_level, 1);
    push(800);
    check("ramp_level2", fifo_level, 2);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("ramp_out[%0d]", i), $signed(out_pcm), ramp_exp[i]);
      check($sformatf("ramp_underrun[%0d]", i), underrun, undr_exp[i]);
    end

    // Negative values floor toward -inf
    reset_dut();
    push(-3);
    push(-3);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("neg_out[%0d]", i), $signed(out_pcm), neg_exp[i]);
    end

    // Full-scale swing, no wrap
    reset_dut();
    push(-32768);
    push(32767);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("fs_out[%0d]", i), $signed(out_pcm), fs_exp[i]);
    end

    // Backpressure: data advances only on accepted handshakes
    reset_dut();
    in_valid = 1'b1;
    in_data  = 16'd1;
    for (int e = 1; e <= 28; e++) begin
      logic rdy;
      rdy = in_ready;
      tick();
      if (rdy) in_data = in_data + 16'd1;
      if (e == 5) begin
        check("bp_full_level", fifo_level, 4);
        check("bp_full_ready", in_ready, 0);
      end
      if (e == 7) begin
        check("bp_pop_while_full_level", fifo_level, 3);
        check("bp_pop_while_full_ready", in_ready, 1);
      end
      if (e >= 4 && (e % 4) == 0)
        check($sformatf("bp_sample[%0d]", (e - 4) / 4), $signed(out_pcm),
              bp_base + (e - 4) / 4);
    end
    in_valid = 1'b0;

    // Asynchronous reset mid-segment, then a fresh ramp
    reset_dut();
    push(400);
    push(800);
    repeat (4) tick();
    check("async_pre_out", $signed(out_pcm), ramp_exp[2]);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", $signed(out_pcm), 0);
    check("async_level", fifo_level, 0);
    check("async_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push(400);
    push(800);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rerun_out[%0d]", i), $signed(out_pcm), ramp_exp[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
